// File: rtl/zmod_rx_lane_align.sv
// Receive-side word aligner and link monitor for the zmod LVDS loopback link.
// Optional lane timeout (lane_fail, slip counting) is built with ZMOD_ALIGN_TIMEOUT_EN.
module zmod_rx_lane_align #(
    parameter int               NLANE       = 4,
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] TRAIN_WORD  = 8'hA5,
    parameter int               MATCH_COUNT = 4,
    parameter int               LOSS_COUNT  = 8,
    parameter int               SLIP_WAIT   = 3,
    parameter int               MAX_SLIPS   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   din_valid,
    input  logic [NLANE*WIDTH-1:0] din,
    input  logic                   err_clear,
    output logic [NLANE-1:0]       bitslip,
    output logic [NLANE-1:0]       lane_locked,
    output logic                   all_locked,
    output logic [NLANE*16-1:0]    err_count
`ifdef ZMOD_ALIGN_TIMEOUT_EN
    ,
    output logic [NLANE-1:0]       lane_fail
`endif
);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_SLIP   = 2'd1,
        ST_WAIT   = 2'd2,
        ST_LOCKED = 2'd3
    } state_t;

    localparam logic [7:0] MATCH_LAST = 8'(MATCH_COUNT - 1);
    localparam logic [7:0] LOSS_LAST  = 8'(LOSS_COUNT - 1);
    localparam logic [3:0] WAIT_LOAD  = 4'(SLIP_WAIT);

    for (genvar l = 0; l < NLANE; l++) begin : g_lane
        state_t      state_r, state_s;
        logic [7:0]  match_cnt_r, match_cnt_s;
        logic [7:0]  miss_cnt_r, miss_cnt_s;
        logic [3:0]  wait_cnt_r, wait_cnt_s;
        logic [15:0] err_cnt_r;
        logic        slip_r, locked_r;
        logic        err_inc_s, slip_inc_s, slip_clr_s, match_s;

        assign match_s = (din[l*WIDTH +: WIDTH] == TRAIN_WORD);

        // Next-state and counter updates for one lane
        always_comb begin
            state_s     = state_r;
            match_cnt_s = match_cnt_r;
            miss_cnt_s  = miss_cnt_r;
            wait_cnt_s  = wait_cnt_r;
            err_inc_s   = 1'b0;
            slip_inc_s  = 1'b0;
            slip_clr_s  = 1'b0;
            case (state_r)
                ST_SEARCH: begin
                    if (!din_valid) begin
                        state_s = ST_SEARCH;
                    end else if (match_s) begin
                        if (match_cnt_r == MATCH_LAST) begin
                            state_s     = ST_LOCKED;
                            match_cnt_s = 8'd0;
                            miss_cnt_s  = 8'd0;
                            slip_clr_s  = 1'b1;
                        end else begin
                            match_cnt_s = match_cnt_r + 8'd1;
                        end
                    end else begin
                        match_cnt_s = 8'd0;
                        state_s     = ST_SLIP;
                    end
                end
                ST_SLIP: begin
                    wait_cnt_s = WAIT_LOAD;
                    slip_inc_s = 1'b1;
                    state_s    = ST_WAIT;
                end
                ST_WAIT: begin
                    // din is ignored here; the deserializer output is settling
                    if (wait_cnt_r <= 4'd1) begin
                        wait_cnt_s = 4'd0;
                        state_s    = ST_SEARCH;
                    end else begin
                        wait_cnt_s = wait_cnt_r - 4'd1;
                    end
                end
                ST_LOCKED: begin
                    if (!din_valid) begin
                        state_s = ST_LOCKED;
                    end else if (match_s) begin
                        miss_cnt_s = 8'd0;
                    end else begin
                        err_inc_s = 1'b1;
                        if (miss_cnt_r == LOSS_LAST) begin
                            state_s     = ST_SEARCH;
                            miss_cnt_s  = 8'd0;
                            match_cnt_s = 8'd0;
                            slip_clr_s  = 1'b1;
                        end else begin
                            miss_cnt_s = miss_cnt_r + 8'd1;
                        end
                    end
                end
                default: begin
                    state_s = ST_SEARCH;
                end
            endcase
        end

        // Lane state, counters and registered lane outputs
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_r     <= ST_SEARCH;
                match_cnt_r <= 8'd0;
                miss_cnt_r  <= 8'd0;
                wait_cnt_r  <= 4'd0;
                err_cnt_r   <= 16'd0;
                slip_r      <= 1'b0;
                locked_r    <= 1'b0;
            end else begin
                state_r     <= state_s;
                match_cnt_r <= match_cnt_s;
                miss_cnt_r  <= miss_cnt_s;
                wait_cnt_r  <= wait_cnt_s;
                slip_r      <= (state_r == ST_SLIP);
                locked_r    <= (state_r == ST_LOCKED);
                if (err_clear) begin
                    err_cnt_r <= 16'd0;
                end else if (err_inc_s && (err_cnt_r != 16'hFFFF)) begin
                    err_cnt_r <= err_cnt_r + 16'd1;
                end
            end
        end

        assign bitslip[l]           = slip_r;
        assign lane_locked[l]       = locked_r;
        assign err_count[l*16 +: 16] = err_cnt_r;

`ifdef ZMOD_ALIGN_TIMEOUT_EN
        localparam logic [4:0] FAIL_AT = 5'(MAX_SLIPS - 1);
        logic [4:0] slip_cnt_r;
        logic       fail_r;

        // Saturating slip count; lane_fail latches until err_clear or reset
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                slip_cnt_r <= 5'd0;
                fail_r     <= 1'b0;
            end else begin
                if (slip_clr_s) begin
                    slip_cnt_r <= 5'd0;
                end else if (slip_inc_s && (slip_cnt_r != 5'd31)) begin
                    slip_cnt_r <= slip_cnt_r + 5'd1;
                end
                if (err_clear) begin
                    fail_r <= 1'b0;
                end else if (slip_inc_s && (slip_cnt_r >= FAIL_AT)) begin
                    fail_r <= 1'b1;
                end
            end
        end

        assign lane_fail[l] = fail_r;
`else
        logic slip_unused_s;
        assign slip_unused_s = slip_inc_s | slip_clr_s | (MAX_SLIPS == 0);
`endif
    end

    // Registered AND of the per-lane lock flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            all_locked <= 1'b0;
        end else begin
            all_locked <= &lane_locked;
        end
    end

endmodule
